// File: rtl/brent_stream_accumulator_if.sv
// Operand/result stream bundle for brent_stream_accumulator (valid/ready on both sides).
// The abort signal exists only when BRENT_ACC_ABORT_EN is defined.
interface brent_stream_accumulator_if #(
  parameter int N     = 32,
  parameter int CNT_W = 8
);
  logic                 start;
  logic [CNT_W-1:0]     len;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_data;
  logic                 in_cin;
  logic                 out_valid;
  logic                 out_ready;
  logic [N+CNT_W-1:0]   out_sum;
`ifdef BRENT_ACC_ABORT_EN
  logic                 abort;
`endif

  modport master (
`ifdef BRENT_ACC_ABORT_EN
    output abort,
`endif
    output start, len, in_valid, in_data, in_cin, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
`ifdef BRENT_ACC_ABORT_EN
    input  abort,
`endif
    input  start, len, in_valid, in_data, in_cin, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/brent_stream_accumulator.sv
// Burst accumulator: sums LEN operand beats (data + cin) through one Brent-Kung adder.
// Define BRENT_ACC_ABORT_EN to add the abort input that cancels a burst in ACCUM or DONE.
module brent_stream_accumulator #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input logic                       clk,
  input logic                       rst,
  brent_stream_accumulator_if.slave bus
);
  localparam int LOGN = (N > 1) ? $clog2(N) : 1;
  localparam int NP   = 1 << LOGN;
  localparam int AW   = N + CNT_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [N:0]       bk_sum;
  logic             beat, abort_w;

  // Operands are zero-padded to a power of two so the up/down sweep covers every bit.
  function automatic logic [N:0] brent_add(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic         cin);
    logic [NP-1:0] g;
    logic [NP-1:0] p;
    logic [N-1:0]  hp;
    logic [N:0]    s;
    g        = '0;
    p        = '0;
    hp       = a ^ b;
    g[N-1:0] = a & b;
    p[N-1:0] = hp;
    g[0]     = g[0] | (p[0] & cin);
    for (int d = 0; d < LOGN; d++)
      for (int i = 0; i < NP; i++)
        if ((i + 1) % (2 << d) == 0) begin
          g[i] = g[i] | (p[i] & g[i - (1 << d)]);
          p[i] = p[i] & p[i - (1 << d)];
        end
    for (int d = LOGN - 2; d >= 0; d--)
      for (int i = 0; i < NP; i++)
        if (((i + 1) % (2 << d) == (1 << d)) && (i >= (2 << d))) begin
          g[i] = g[i] | (p[i] & g[i - (1 << d)]);
          p[i] = p[i] & p[i - (1 << d)];
        end
    s[0] = hp[0] ^ cin;
    for (int i = 1; i < N; i++)
      s[i] = hp[i] ^ g[i - 1];
    s[N] = g[N - 1];
    return s;
  endfunction

`ifdef BRENT_ACC_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  assign beat    = bus.in_valid & (state_q == ACCUM);
  assign bk_sum  = brent_add(acc_q[N-1:0], bus.in_data, bus.in_cin);
  assign cnt_inc = cnt_q + CNT_W'(1);

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          len_d   = bus.len;
          state_d = (bus.len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = {acc_q[AW-1:N] + CNT_W'(bk_sum[N]), bk_sum[N-1:0]};
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides any beat or result handshake in the same cycle.
    if (abort_w && (state_q != IDLE)) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end
endmodule

// File: tb/tb_brent_stream_accumulator.sv
// Directed and randomized bench for brent_stream_accumulator against a plain-arithmetic burst sum.
// Abort scenarios are included when BRENT_ACC_ABORT_EN is defined.
module tb_brent_stream_accumulator;
  localparam int N     = 32;
  localparam int CNT_W = 8;
  localparam int AW    = N + CNT_W;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  brent_stream_accumulator_if #(.N(N), .CNT_W(CNT_W)) bus ();

  brent_stream_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int l);
    bus.start = 1'b1;
    bus.len   = CNT_W'(l);
    step();
    bus.start = 1'b0;
  endtask

  task automatic send_beat(input logic [N-1:0] d, input logic c, input int gap);
    int k;
    bus.in_valid = 1'b0;
    repeat (gap) step();
    bus.in_data  = d;
    bus.in_cin   = c;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      step();
      k++;
    end
    chk1("beat_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int hold, input logic [AW-1:0] exp, input string tag);
    int k;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      step();
      k++;
    end
    chk1({tag, "_out_valid"}, bus.out_valid, 1'b1);
    for (int h = 0; h < hold; h++) begin
      chkw({tag, "_held_sum"}, bus.out_sum, exp);
      chk1({tag, "_held_in_ready"}, bus.in_ready, 1'b0);
      step();
    end
    chk1({tag, "_valid_held"}, bus.out_valid, 1'b1);
    chkw({tag, "_sum"}, bus.out_sum, exp);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk1({tag, "_valid_drop"}, bus.out_valid, 1'b0);
    chkw({tag, "_sum_kept"}, bus.out_sum, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]  d0, d1;
    logic [AW-1:0] exp;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef BRENT_ACC_ABORT_EN
    bus.abort     = 1'b0;
`endif
    #1;
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk1("reset_in_ready", bus.in_ready, 1'b0);
    chkw("reset_out_sum", bus.out_sum, '0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // T1: len=3, beats 1,2,3 with no gaps; result visible L+1 cycles after start.
    bus.start    = 1'b1;
    bus.len      = 8'd3;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd1;
    bus.in_cin   = 1'b0;
    step();
    bus.start = 1'b0;
    chk1("t1_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_data = 32'd2;
    step();
    bus.in_data = 32'd3;
    chk1("t1_not_done_early", bus.out_valid, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk1("t1_out_valid_at_4", bus.out_valid, 1'b1);
    chk1("t1_in_ready_done", bus.in_ready, 1'b0);
    collect(0, 40'd6, "t1");

    // T2: carries out of the low word land in the upper accumulator bits.
    start_burst(2);
    send_beat(32'hFFFF_FFFF, 1'b1, 0);
    send_beat(32'hFFFF_FFFF, 1'b1, 0);
    collect(0, 40'h2_0000_0000, "t2");

    // T3: zero-length burst.
    start_burst(0);
    chk1("t3_out_valid", bus.out_valid, 1'b1);
    chkw("t3_out_sum", bus.out_sum, '0);
    chk1("t3_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk1("t3_valid_drop", bus.out_valid, 1'b0);
    chk1("t3_in_ready_idle", bus.in_ready, 1'b0);

    // T4: input gaps and a stalled consumer.
    d0 = $urandom;
    d1 = $urandom;
    start_burst(2);
    send_beat(d0, 1'b0, 3);
    send_beat(d1, 1'b0, 3);
    collect(5, {8'b0, d0} + {8'b0, d1}, "t4");

    // T5: asynchronous reset in the middle of a burst.
    start_burst(4);
    send_beat(32'd5, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    chk1("t5_rst_out_valid", bus.out_valid, 1'b0);
    chk1("t5_rst_in_ready", bus.in_ready, 1'b0);
    chkw("t5_rst_out_sum", bus.out_sum, '0);
    step();
    rst = 1'b0;
    step();
    start_burst(1);
    send_beat(32'd7, 1'b0, 0);
    collect(0, 40'd7, "t5");

`ifdef BRENT_ACC_ABORT_EN
    // T6: abort coinciding with the second beat of four.
    start_burst(4);
    send_beat(32'd11, 1'b0, 0);
    bus.in_data  = 32'd22;
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    step();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk1("t6_in_ready", bus.in_ready, 1'b0);
    chk1("t6_out_valid", bus.out_valid, 1'b0);
    chkw("t6_out_sum", bus.out_sum, '0);
    repeat (3) step();
    chk1("t6_no_result", bus.out_valid, 1'b0);
`endif

    // Random bursts: expected value is the plain sum of (data + cin) over the burst.
    for (int b = 0; b < 100; b++) begin
      int          l;
      int          ab;
      logic        aborted;
      logic [N-1:0] d;
      logic        c;
      l       = int'($urandom_range(0, 6));
      ab      = -1;
      aborted = 1'b0;
      exp     = '0;
`ifdef BRENT_ACC_ABORT_EN
      if (l > 0 && $urandom_range(0, 4) == 0) ab = int'($urandom_range(0, l - 1));
`endif
      start_burst(l);
      for (int j = 0; j < l && !aborted; j++) begin
        d = $urandom;
        c = 1'($urandom_range(0, 1));
        if (j == ab) begin
`ifdef BRENT_ACC_ABORT_EN
          bus.in_data  = d;
          bus.in_cin   = c;
          bus.in_valid = 1'b1;
          bus.abort    = 1'b1;
          step();
          bus.abort    = 1'b0;
          bus.in_valid = 1'b0;
          chk1("rand_abort_out_valid", bus.out_valid, 1'b0);
          chk1("rand_abort_in_ready", bus.in_ready, 1'b0);
          chkw("rand_abort_out_sum", bus.out_sum, '0);
`endif
          aborted = 1'b1;
        end else begin
          send_beat(d, c, int'($urandom_range(0, 2)));
          exp = exp + {8'b0, d} + {39'b0, c};
        end
      end
      if (!aborted) collect(int'($urandom_range(0, 3)), exp, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
